mem_io_bridge: RTL and testbench

- Unified memory and memory-mapped I/O slave directly downstream of the multicycle MIPS core.
- Consumes the core's addr/writedata/memwrite and returns readdata.
- Contains word RAM for instructions and data, an LED register, a byte TX FIFO with valid/ready output, and a compare timer with interrupt flag.
- Read path is combinational (same-cycle readdata); all state updates occur on the rising clk edge.

---
 rtl/mem_io_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 50 +++++
 rtl/mem_io_bridge.sv | 133 +++++++++++++
 tb/tb_mem_io_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants and the address-region decode for mem_io_bridge.
package mem_io_pkg;

  localparam logic [15:0] RAM_BASE_HI  = 16'h0000;
  localparam logic [23:0] MMIO_BASE_HI = 24'hFFFF00;

  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_TX    = 8'h04;
  localparam logic [7:0] OFF_COUNT = 8'h08;
  localparam logic [7:0] OFF_CMP   = 8'h0C;
  localparam logic [7:0] OFF_CTRL  = 8'h10;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_FLAG   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_OVF    = 3;

  // TX status word: count occupies [5:0]
  localparam int STAT_EMPTY = 6;
  localparam int STAT_FULL  = 7;
  localparam int STAT_OVF   = 8;

  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;

  function automatic region_e decode_region(input logic [31:0] a);
    if (a[31:16] == RAM_BASE_HI)      return REG_RAM;
    else if (a[31:8] == MMIO_BASE_HI) return REG_MMIO;
    else                              return REG_NONE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is dropped unless a pop happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || pop);
  // Empty head reads as zero so the storage itself needs no reset
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Word RAM plus LED / TX FIFO / compare-timer MMIO behind the MIPS core bus.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMER_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic [15:0] io_led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int RAW = $clog2(MEM_WORDS);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]        ram [MEM_WORDS];
  logic [RAW-1:0]     ram_idx;
  region_e            region;
  logic [7:0]         off;

  logic [TIMER_W-1:0] count, cmp;
  logic               run, flag, irq_en, ovf;
  logic               fifo_full, fifo_empty;
  logic [FCW-1:0]     fifo_count;

  logic wr_ram, wr_led, wr_tx, wr_count, wr_cmp, wr_ctrl;
  logic tx_pop, match, flag_set, ovf_set;

  assign region  = decode_region(addr);
  assign off     = addr[7:0];
  assign ram_idx = addr[RAW+1:2];

  assign wr_ram   = memwrite && (region == REG_RAM);
  assign wr_led   = memwrite && (region == REG_MMIO) && (off == OFF_LED);
  assign wr_tx    = memwrite && (region == REG_MMIO) && (off == OFF_TX);
  assign wr_count = memwrite && (region == REG_MMIO) && (off == OFF_COUNT);
  assign wr_cmp   = memwrite && (region == REG_MMIO) && (off == OFF_CMP);
  assign wr_ctrl  = memwrite && (region == REG_MMIO) && (off == OFF_CTRL);

  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= writedata;
  end

  assign tx_valid = !fifo_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign ovf_set  = wr_tx && fifo_full && !tx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_tx),
    .din   (writedata[7:0]),
    .pop   (tx_pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A COUNT store takes priority over both increment and compare match
  assign match    = run && (count == cmp);
  assign flag_set = match && !wr_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_led <= '0;
      count  <= '0;
      cmp    <= '1;
      run    <= 1'b0;
      flag   <= 1'b0;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr_led) io_led <= writedata[15:0];
      if (wr_cmp) cmp <= writedata[TIMER_W-1:0];

      if (wr_count)   count <= writedata[TIMER_W-1:0];
      else if (match) count <= '0;
      else if (run)   count <= count + TIMER_W'(1);

      if (wr_ctrl) begin
        run    <= writedata[CTRL_RUN];
        irq_en <= writedata[CTRL_IRQ_EN];
      end

      if (flag_set)                            flag <= 1'b1;
      else if (wr_ctrl && writedata[CTRL_FLAG]) flag <= 1'b0;

      if (ovf_set)                             ovf <= 1'b1;
      else if (wr_ctrl && writedata[CTRL_OVF]) ovf <= 1'b0;
    end
  end

  assign timer_irq = flag && irq_en;

  always_comb begin
    readdata = '0;
    unique case (region)
      REG_RAM: readdata = ram[ram_idx];
      REG_MMIO: begin
        case (off)
          OFF_LED:   readdata = {16'h0, io_led};
          OFF_TX: begin
            readdata[5:0]      = 6'(fifo_count);
            readdata[STAT_EMPTY] = fifo_empty;
            readdata[STAT_FULL]  = fifo_full;
            readdata[STAT_OVF]   = ovf;
          end
          OFF_COUNT: readdata = 32'(count);
          OFF_CMP:   readdata = 32'(cmp);
          OFF_CTRL: begin
            readdata[CTRL_RUN]    = run;
            readdata[CTRL_FLAG]   = flag;
            readdata[CTRL_IRQ_EN] = irq_en;
            readdata[CTRL_OVF]    = ovf;
          end
          default:   readdata = '0;
        endcase
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: vector table plus TX scoreboard and timer sequences.
module tb_mem_io_bridge;

  localparam logic [31:0] A_LED   = 32'hFFFF0000;
  localparam logic [31:0] A_TX    = 32'hFFFF0004;
  localparam logic [31:0] A_COUNT = 32'hFFFF0008;
  localparam logic [31:0] A_CMP   = 32'hFFFF000C;
  localparam logic [31:0] A_CTRL  = 32'hFFFF0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] writedata = '0;
  logic        memwrite = 1'b0;
  logic [31:0] readdata;
  logic [15:0] io_led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        timer_irq;

  int total = 0;
  int bad = 0;

  logic [7:0] sbq[$];

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;
  vec_t vecs[$];

  mem_io_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .readdata  (readdata),
    .io_led    (io_led),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    memwrite = 1'b0;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    if (sbq.size() < 8) sbq.push_back(b);
    wr(A_TX, {24'h0, b});
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 20 && tx_valid; i++) begin
      if (sbq.size() == 0) check("drain_extra", {24'h0, tx_data}, 32'hxxxxxxxx);
      else check("drain_data", {24'h0, tx_data}, {24'h0, sbq.pop_front()});
      tick();
    end
    tx_ready = 1'b0;
    check("drain_valid", {31'h0, tx_valid}, 32'h0);
    check("drain_left", sbq.size(), 0);
  endtask

  initial begin
    // ---------------- reset state
    #12;
    check("rst_led", {16'h0, io_led}, 32'h0);
    check("rst_txv", {31'h0, tx_valid}, 32'h0);
    check("rst_txd", {24'h0, tx_data}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_cmp", A_CMP, 32'hFFFFFFFF);
    rd("rst_count", A_COUNT, 32'h0);
    rd("rst_status", A_TX, 32'h40);
    #5 reset = 1'b1;
    tick();

    // ---------------- vector table: {we, addr, data/expected}
    vecs.push_back('{1'b1, 32'h00000044, 32'h12345678});
    vecs.push_back('{1'b0, 32'h00000044, 32'h12345678});
    vecs.push_back('{1'b0, 32'h00000045, 32'h12345678});
    vecs.push_back('{1'b0, 32'h00000144, 32'h12345678});
    vecs.push_back('{1'b1, 32'h00000048, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h00000048, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h00000044, 32'h12345678});
    vecs.push_back('{1'b1, 32'h00010044, 32'hFFFFFFFF});
    vecs.push_back('{1'b0, 32'h00010044, 32'h00000000});
    vecs.push_back('{1'b0, 32'h00000044, 32'h12345678});
    vecs.push_back('{1'b1, A_LED,        32'hABCDBEEF});
    vecs.push_back('{1'b0, A_LED,        32'h0000BEEF});
    vecs.push_back('{1'b1, A_CMP,        32'h00001234});
    vecs.push_back('{1'b0, A_CMP,        32'h00001234});
    vecs.push_back('{1'b0, 32'hFFFF0014, 32'h00000000});
    vecs.push_back('{1'b0, 32'hFFFE0000, 32'h00000000});
    vecs.push_back('{1'b0, A_TX,         32'h00000040});
    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].a, vecs[i].d);
      else rd($sformatf("vec%0d", i), vecs[i].a, vecs[i].d);
    end
    check("io_led", {16'h0, io_led}, 32'h0000BEEF);

    // ---------------- same-cycle RAM write returns old value until the edge
    tick();
    addr = 32'h44; writedata = 32'h0BADF00D; memwrite = 1'b1;
    #1 check("ram_old", readdata, 32'h12345678);
    tick();
    memwrite = 1'b0;
    check("ram_new", readdata, 32'h0BADF00D);

    // ---------------- single byte, then a one-cycle pop
    push_byte(8'hA5);
    check("tx_valid1", {31'h0, tx_valid}, 32'h1);
    check("tx_data1", {24'h0, tx_data}, 32'hA5);
    rd("status1", A_TX, 32'h01);
    tx_ready = 1'b1;
    #1 check("pop_head", {24'h0, tx_data}, {24'h0, sbq.pop_front()});
    tick();
    tx_ready = 1'b0;
    check("tx_valid0", {31'h0, tx_valid}, 32'h0);
    rd("status0", A_TX, 32'h40);

    // ---------------- overflow: 9 pushes into depth 8
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    rd("status_ovf", A_TX, 32'h188);
    rd("ctrl_ovf", A_CTRL, 32'h8);
    drain();
    wr(A_CTRL, 32'h8);
    rd("ovf_clr", A_CTRL, 32'h0);

    // ---------------- push and pop while full
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    rd("status_full", A_TX, 32'h88);
    addr = A_TX; writedata = 32'h18; memwrite = 1'b1; tx_ready = 1'b1;
    #1 check("pp_head", {24'h0, tx_data}, {24'h0, sbq.pop_front()});
    sbq.push_back(8'h18);
    tick();
    memwrite = 1'b0; tx_ready = 1'b0;
    rd("status_pp", A_TX, 32'h88);
    drain();

    // ---------------- timer compare
    wr(A_COUNT, 32'h0);
    wr(A_CMP, 32'h4);
    wr(A_CTRL, 32'h5);
    addr = A_COUNT;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("tmr_cnt%0d", k), readdata, (k == 5) ? 32'h0 : 32'(k));
      check($sformatf("tmr_irq%0d", k), {31'h0, timer_irq}, (k == 5) ? 32'h1 : 32'h0);
    end
    wr(A_CTRL, 32'h7);
    check("irq_clr", {31'h0, timer_irq}, 32'h0);
    rd("ctrl_run", A_CTRL, 32'h5);
    rd("cnt_after_clr", A_COUNT, 32'h1);
    tick(); tick();
    rd("cnt3", A_COUNT, 32'h3);
    tick();
    wr(A_CTRL, 32'h7);
    check("set_wins", {31'h0, timer_irq}, 32'h1);
    rd("ctrl_set_wins", A_CTRL, 32'h7);
    wr(A_CTRL, 32'h7);
    check("irq_clr2", {31'h0, timer_irq}, 32'h0);
    wr(A_COUNT, 32'h4);
    wr(A_COUNT, 32'h2);
    check("cnt_wr_irq", {31'h0, timer_irq}, 32'h0);
    rd("cnt_wr_val", A_COUNT, 32'h2);

    // ---------------- counter wrap without match
    wr(A_CTRL, 32'h0);
    wr(A_CMP, 32'h5);
    wr(A_COUNT, 32'hFFFFFFFE);
    wr(A_CTRL, 32'h5);
    tick(); tick();
    rd("wrap_cnt", A_COUNT, 32'h0);
    check("wrap_irq", {31'h0, timer_irq}, 32'h0);

    // ---------------- async reset mid-run
    wr(A_LED, 32'h1234);
    wr(A_CTRL, 32'h0);
    wr(A_COUNT, 32'h0);
    wr(A_CMP, 32'h1);
    wr(A_CTRL, 32'h5);
    tick(); tick();
    check("pre_irq", {31'h0, timer_irq}, 32'h1);
    for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
    check("pre_txv", {31'h0, tx_valid}, 32'h1);
    check("pre_led", {16'h0, io_led}, 32'h1234);
    #2 reset = 1'b0;
    #1;
    check("ar_led", {16'h0, io_led}, 32'h0);
    check("ar_txv", {31'h0, tx_valid}, 32'h0);
    check("ar_txd", {24'h0, tx_data}, 32'h0);
    check("ar_irq", {31'h0, timer_irq}, 32'h0);
    sbq.delete();
    #10 reset = 1'b1;
    tick();
    rd("ram_keep44", 32'h44, 32'h0BADF00D);
    rd("ram_keep48", 32'h48, 32'hDEADBEEF);
    rd("ar_status", A_TX, 32'h40);
    rd("ar_count", A_COUNT, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
